sa_feeder4x4: RTL and testbench

Job sequencer and input skew stage that sits directly upstream of the 4x4 systolic array. It clears the array, then streams four B rows down the array's weight registers. It then feeds A vectors into the left edge with the diagonal skew that the fixed 6-cycle PE multiply pipeline requires. It also emits a per-column valid tag that is cycle-aligned with the array's bottom partial-sum outputs, so the downstream collector needs no timing knowledge.

---
 rtl/sa_pkg.sv | 18 +
 rtl/sa_skew_line.sv | 27 ++
 rtl/sa_feeder4x4.sv | 124 ++++++++++++
 tb/tb_sa_feeder4x4.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// Shared constants and FSM encodings for the 4x4 systolic-array feeder.
// The state encoding is also exported on the top-level debug port.
package sa_pkg;
  localparam int DW           = 16;
  localparam int N            = 4;
  localparam int LAT_PS       = 12;
  localparam int DRAIN_CYCLES = 15;
  // The last column result appears LAT_PS + N - 1 cycles after acceptance.
  localparam int VLD_STAGES   = LAT_PS + N - 1;

  typedef logic [2:0] state_t;

  localparam state_t IDLE   = 3'd0;
  localparam state_t CLEAR  = 3'd1;
  localparam state_t LOAD_B = 3'd2;
  localparam state_t STREAM = 3'd3;
  localparam state_t DRAIN  = 3'd4;
endpackage

// File: rtl/sa_skew_line.sv
// One skew lane: a DEPTH-stage register chain with a synchronous clear and shift enable.
module sa_skew_line #(
  parameter int DEPTH = 1,
  parameter int DW    = 16
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          en_i,
  input  logic          clr_i,
  input  logic [DW-1:0] d_i,
  output logic [DW-1:0] q_o
);
  logic [DW-1:0] sr_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
    end else if (clr_i) begin
      for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
    end else if (en_i) begin
      sr_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
    end
  end

  assign q_o = sr_q[DEPTH-1];
endmodule

// File: rtl/sa_feeder4x4.sv
// Job sequencer and input skew stage for the 4x4 systolic array: clear, load B,
// stream skewed A vectors, drain, and tag bottom-row results with column valids.
module sa_feeder4x4
  import sa_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            start_i,
  input  logic            b_valid_i,
  output logic            b_ready_o,
  input  logic [N*DW-1:0] b_data_i,
  input  logic            a_valid_i,
  output logic            a_ready_o,
  input  logic [N*DW-1:0] a_data_i,
  input  logic            a_last_i,
  output logic            data_clear_o,
  output logic            en_b_shift_bottom_o,
  output logic            en_shift_right_o,
  output logic            en_shift_bottom_o,
  output logic [N*DW-1:0] b_top_in_flat_o,
  output logic [N*DW-1:0] a_left_in_flat_o,
  output logic [N*DW-1:0] ps_top_in_flat_o,
  output logic [N-1:0]    out_col_valid_o,
  output logic            out_last_o,
  output logic            busy_o,
  output logic            done_o,
  output state_t          state_o
);
  // Handshakes: a beat transfers on a rising edge where valid and ready are both high;
  // ready depends only on state, and valid may rise or fall in any cycle.
  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

  state_t                state_q, state_d;
  logic [1:0]            bcnt_q, bcnt_d;
  logic [3:0]            dcnt_q, dcnt_d;
  logic [N*DW-1:0]       bhold_q;
  logic [VLD_STAGES-1:0] vld_q, last_q;
  logic [N*DW-1:0]       a_in;
  logic                  b_acc, a_acc, shift_en;

  assign b_ready_o           = (state_q == LOAD_B);
  assign a_ready_o           = (state_q == STREAM);
  assign data_clear_o        = (state_q == CLEAR);
  assign b_acc               = b_valid_i & b_ready_o;
  assign a_acc               = a_valid_i & a_ready_o;
  assign shift_en            = (state_q == STREAM) || (state_q == DRAIN);
  assign en_b_shift_bottom_o = b_acc;
  assign en_shift_right_o    = shift_en;
  assign en_shift_bottom_o   = shift_en || (state_q == LOAD_B);
  assign b_top_in_flat_o     = b_acc ? b_data_i : bhold_q;
  assign ps_top_in_flat_o    = '0;
  assign busy_o              = (state_q != IDLE);
  assign done_o              = (state_q == DRAIN) && (dcnt_q == DRAIN_LAST);
  assign out_col_valid_o     = vld_q[VLD_STAGES-1 -: N];
  assign out_last_o          = last_q[VLD_STAGES-1];
  assign state_o             = state_q;

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      IDLE:   if (start_i) state_d = CLEAR;
      CLEAR: begin
        state_d = LOAD_B;
        bcnt_d  = '0;
        dcnt_d  = '0;
      end
      LOAD_B: if (b_acc) begin
        bcnt_d = bcnt_q + 2'd1;
        if (bcnt_q == 2'd3) state_d = STREAM;
      end
      STREAM: if (a_acc && a_last_i) state_d = DRAIN;
      DRAIN: begin
        dcnt_d = dcnt_q + 4'd1;
        if (dcnt_q == DRAIN_LAST) begin
          state_d = IDLE;
          dcnt_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      bcnt_q  <= '0;
      dcnt_q  <= '0;
      bhold_q <= '0;
      vld_q   <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      dcnt_q  <= dcnt_d;
      if (b_acc) bhold_q <= b_data_i;
      if (data_clear_o) begin
        vld_q  <= '0;
        last_q <= '0;
      end else if (shift_en) begin
        vld_q  <= {vld_q[VLD_STAGES-2:0], a_acc};
        last_q <= {last_q[VLD_STAGES-2:0], a_acc & a_last_i};
      end
    end
  end

  // Cycles without an accepted beat push a zero vector so the free-running PEs see bubbles.
  assign a_in = a_acc ? a_data_i : '0;

  for (genvar r = 0; r < N; r++) begin : g_lane
    sa_skew_line #(
      .DEPTH (r + 1),
      .DW    (DW)
    ) u_skew (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .en_i    (shift_en),
      .clr_i   (data_clear_o),
      .d_i     (a_in[r*DW +: DW]),
      .q_o     (a_left_in_flat_o[r*DW +: DW])
    );
  end
endmodule

// File: tb/tb_sa_feeder4x4.sv
// Directed bench for sa_feeder4x4: per-job A-vector tables, a per-cycle expected-output
// monitor, and hand sequences for reset abort, B backpressure and control edges.
module tb_sa_feeder4x4;
  import sa_pkg::*;
  localparam int W = N*DW;

  typedef struct {
    logic         v;
    logic         last;
    logic         st;
    logic [W-1:0] a;
    logic         tag;
    logic         xlast;
  } vec_t;

  logic         clk, rst_n, start, b_valid, a_valid, a_last;
  logic [W-1:0] b_data, a_data;
  logic         b_ready, a_ready, data_clear, en_b_shift_bottom, en_shift_right, en_shift_bottom;
  logic [W-1:0] b_top, a_left, ps_top;
  logic [N-1:0] out_col_valid;
  logic         out_last, busy, done;
  state_t       state;

  int           n_vec = 0;
  int           n_err = 0;
  int           cyc = 0;
  int           base = 0;
  logic         mon_en = 1'b0;
  logic [W-1:0] b_hold;
  logic [DW-1:0] exp_lane [N][64];
  logic [N-1:0] exp_cv   [64];
  logic         exp_last [64];
  logic         exp_done [64];
  vec_t         tbl[$];
  logic [W-1:0] brow[4];

  sa_feeder4x4 dut (
    .clk_i               (clk),
    .rst_n_i             (rst_n),
    .start_i             (start),
    .b_valid_i           (b_valid),
    .b_ready_o           (b_ready),
    .b_data_i            (b_data),
    .a_valid_i           (a_valid),
    .a_ready_o           (a_ready),
    .a_data_i            (a_data),
    .a_last_i            (a_last),
    .data_clear_o        (data_clear),
    .en_b_shift_bottom_o (en_b_shift_bottom),
    .en_shift_right_o    (en_shift_right),
    .en_shift_bottom_o   (en_shift_bottom),
    .b_top_in_flat_o     (b_top),
    .a_left_in_flat_o    (a_left),
    .ps_top_in_flat_o    (ps_top),
    .out_col_valid_o     (out_col_valid),
    .out_last_o          (out_last),
    .busy_o              (busy),
    .done_o              (done),
    .state_o             (state)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, W'(act), W'(exp));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] pack4(input int e0, input int e1, input int e2, input int e3);
    return {DW'(e3), DW'(e2), DW'(e1), DW'(e0)};
  endfunction

  task automatic add(input logic v, input logic last, input logic st, input logic [W-1:0] a,
                     input logic tag, input logic xlast);
    vec_t e;
    e.v = v; e.last = last; e.st = st; e.a = a; e.tag = tag; e.xlast = xlast;
    tbl.push_back(e);
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 64; i++) begin
      for (int r = 0; r < N; r++) exp_lane[r][i] = '0;
      exp_cv[i] = '0;
      exp_last[i] = 1'b0;
      exp_done[i] = 1'b0;
    end
  endtask

  task automatic reset_chk(input string tag);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_done"}, done, 1'b0);
    chk1({tag, "_clear"}, data_clear, 1'b0);
    chk1({tag, "_en_b"}, en_b_shift_bottom, 1'b0);
    chk1({tag, "_en_r"}, en_shift_right, 1'b0);
    chk1({tag, "_en_bot"}, en_shift_bottom, 1'b0);
    chk1({tag, "_a_ready"}, a_ready, 1'b0);
    chk1({tag, "_b_ready"}, b_ready, 1'b0);
    chk1({tag, "_last"}, out_last, 1'b0);
    chk({tag, "_colv"}, W'(out_col_valid), '0);
    chk({tag, "_a_left"}, a_left, '0);
    chk({tag, "_b_top"}, b_top, '0);
    chk({tag, "_ps_top"}, ps_top, '0);
    chk({tag, "_state"}, W'(state), W'(IDLE));
  endtask

  // Scoreboard: compares array-facing outputs against the expected tables every cycle of a job
  always @(negedge clk) begin : mon
    int idx;
    idx = cyc - base;
    if (mon_en && idx >= 0 && idx < 64) begin
      for (int r = 0; r < N; r++)
        chk($sformatf("lane%0d@%0d", r, idx), W'(a_left[r*DW +: DW]), W'(exp_lane[r][idx]));
      chk($sformatf("colv@%0d", idx), W'(out_col_valid), W'(exp_cv[idx]));
      chk1($sformatf("out_last@%0d", idx), out_last, exp_last[idx]);
      chk1($sformatf("done@%0d", idx), done, exp_done[idx]);
    end
  end

  // One full job driven from brow[] and tbl[]; abort_at >= 0 pulls reset at that table row.
  task automatic run_job(input bit toggle_b, input int abort_at);
    int i, k, rel, rel_last;
    clear_exp();
    b_valid = 1'b0; a_valid = 1'b0; a_last = 1'b0; start = 1'b1;
    rel_last = 0;
    @(negedge clk);
    chk1("idle_busy", busy, 1'b0);
    chk("idle_state", W'(state), W'(IDLE));
    tick();
    start = 1'b0;
    @(negedge clk);
    chk1("clear_pulse", data_clear, 1'b1);
    chk1("clear_busy", busy, 1'b1);
    chk1("clear_b_ready", b_ready, 1'b0);
    tick();
    i = 0; k = 0;
    while (i < 4 && k < 20) begin
      b_valid = toggle_b ? (k % 2 == 0) : 1'b1;
      b_data  = b_valid ? brow[i] : {N{16'hdead}};
      @(negedge clk);
      chk1("ld_b_ready", b_ready, 1'b1);
      chk1("ld_en_b_shift", en_b_shift_bottom, b_valid);
      chk1("ld_en_shift_bottom", en_shift_bottom, 1'b1);
      chk1("ld_en_shift_right", en_shift_right, 1'b0);
      chk1("ld_data_clear", data_clear, 1'b0);
      if (b_valid) b_hold = brow[i];
      chk("ld_b_top", b_top, b_hold);
      if (b_valid) i++;
      k++;
      tick();
    end
    if (i < 4) chk("ld_timeout_beats", W'(i), W'(4));
    b_valid = 1'b0;
    base = cyc;
    mon_en = 1'b1;
    foreach (tbl[j]) begin
      a_valid = tbl[j].v; a_last = tbl[j].last; start = tbl[j].st; a_data = tbl[j].a;
      @(negedge clk);
      chk("st_state", W'(state), W'(STREAM));
      chk1("st_a_ready", a_ready, 1'b1);
      chk1("st_b_ready", b_ready, 1'b0);
      chk1("st_en_right", en_shift_right, 1'b1);
      chk1("st_en_bottom", en_shift_bottom, 1'b1);
      if (j == abort_at) begin
        #1 rst_n = 1'b0;
        #1 reset_chk("abort");
        mon_en = 1'b0;
        a_valid = 1'b0; a_last = 1'b0; start = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk1("abort_no_done", done, 1'b0);
          chk1("abort_idle", busy, 1'b0);
        end
        tick();
        rst_n = 1'b1;
        b_hold = '0;
        tick();
        return;
      end
      if (tbl[j].v) begin
        rel = cyc + 1 - base;
        for (int r = 0; r < N; r++) exp_lane[r][rel + r] = tbl[j].a[r*DW +: DW];
        for (int c = 0; c < N; c++) exp_cv[rel + LAT_PS - 1 + c][c] = tbl[j].tag;
        if (tbl[j].xlast) begin
          exp_last[rel + 14] = 1'b1;
          exp_done[rel + 14] = 1'b1;
          rel_last = rel;
        end
      end
      tick();
      if (tbl[j].v && tbl[j].last) break;
    end
    a_valid = 1'b0; a_last = 1'b0; start = 1'b0;
    for (int d = 0; d < DRAIN_CYCLES; d++) begin
      @(negedge clk);
      chk("dr_state", W'(state), W'(DRAIN));
      chk1("dr_a_ready", a_ready, 1'b0);
      chk1("dr_en_right", en_shift_right, 1'b1);
      chk1("dr_busy", busy, 1'b1);
      tick();
    end
    @(negedge clk);
    chk("end_idle_idx", W'(cyc - base), W'(rel_last + 15));
    chk("end_state", W'(state), W'(IDLE));
    chk1("end_busy", busy, 1'b0);
    chk1("end_en_right", en_shift_right, 1'b0);
    chk1("end_en_bottom", en_shift_bottom, 1'b0);
    repeat (2) tick();
    mon_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; b_valid = 1'b0; a_valid = 1'b0; a_last = 1'b0;
    b_data = '0; a_data = '0; b_hold = '0;
    repeat (3) @(negedge clk);
    reset_chk("por");
    tick();
    rst_n = 1'b1;
    tick();

    // Abort during STREAM: reset on the second A row
    for (int i = 0; i < 4; i++) brow[i] = pack4(i + 1, i + 2, i + 3, i + 4);
    tbl.delete();
    add(1, 0, 0, pack4(7, 7, 7, 7), 1, 0);
    add(1, 0, 0, pack4(8, 8, 8, 8), 1, 0);
    add(1, 1, 0, pack4(9, 9, 9, 9), 1, 1);
    run_job(1'b0, 1);

    // Identity B, single A vector {1,2,3,4}; rows sent row3 first
    for (int i = 0; i < 4; i++) brow[i] = W'(1) << ((3 - i) * DW);
    tbl.delete();
    add(1, 1, 0, pack4(1, 2, 3, 4), 1, 1);
    run_job(1'b0, -1);

    // B = 1..16 row-major with b_valid toggling; three back-to-back A vectors
    for (int i = 0; i < 4; i++)
      brow[i] = pack4(4*(3-i) + 1, 4*(3-i) + 2, 4*(3-i) + 3, 4*(3-i) + 4);
    tbl.delete();
    add(1, 0, 0, pack4(1, 1, 1, 1), 1, 0);
    add(1, 0, 0, pack4(1, 0, 0, 0), 1, 0);
    add(1, 1, 0, pack4(0, 2, 0, 0), 1, 1);
    run_job(1'b1, -1);

    // Three-cycle bubble with junk data, a stray a_last and a start that must be ignored
    tbl.delete();
    add(1, 0, 0, pack4(5, 6, 7, 8), 1, 0);
    add(0, 0, 0, pack4(16'hbeef, 16'hbeef, 16'hbeef, 16'hbeef), 0, 0);
    add(0, 1, 1, pack4(16'hbeef, 16'hbeef, 16'hbeef, 16'hbeef), 0, 0);
    add(0, 0, 0, pack4(16'hbeef, 16'hbeef, 16'hbeef, 16'hbeef), 0, 0);
    add(1, 0, 0, pack4(9, 10, 11, 12), 1, 0);
    add(1, 1, 0, pack4(16'hffff, 0, 16'h8000, 1), 1, 1);
    run_job(1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
